mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and load/store port. It accepts one request at a time, sequences the memory handshake and returns the read data or write acknowledge to the owning port. It also drives the stall signals the hazard logic uses to freeze the fetch and memory stages while a transaction is pending.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the instruction
//   fetch port (IF) and the load/store port (LS). One transaction is in flight
//   at a time. Completion returns a one-cycle rvalid to the owning port.
//
//   State table:
//     IDLE    | no transaction; grants may be issued this cycle
//     BUSY_IF | fetch in flight; mem_* held until mem_ready_i or timeout
//     BUSY_LS | load/store in flight; mem_* held until mem_ready_i or timeout
//
//   Ports:
//     clk_i, rst_i                  clock, async active-high reset
//     if_req_i/if_addr_i            fetch request
//     if_gnt_o                      fetch accepted (combinational)
//     if_rvalid_o/if_rdata_o        fetch data return
//     ls_req_i/ls_we_i/ls_be_i/
//     ls_addr_i/ls_wdata_i          load/store request
//     ls_gnt_o                      load/store accepted (combinational)
//     ls_rvalid_o/ls_rdata_o        load data / store done
//     err_o                         transaction aborted by timeout
//     mem_req_o/mem_we_o/mem_be_o/
//     mem_addr_o/mem_wdata_o        memory request fields (registered)
//     mem_ready_i/mem_rdata_i       memory completion and read data
//     stall_if_o/stall_mem_o        pipeline stall requests
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_if_o,
  output logic                stall_mem_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_e;

  state_e              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic                busy;
  logic                if_starved;
  logic                done;
  logic                abort;
  logic [DATA_W-1:0]   ret_data;

  assign busy       = (state_q != IDLE);
  // LS normally wins as the older instruction; IF is forced once starved.
  assign if_starved = if_req_i && (streak_q == 4'(STARVE_LIMIT));
  assign ls_gnt_o   = !busy && ls_req_i && !if_starved;
  assign if_gnt_o   = !busy && if_req_i && !ls_gnt_o;

  assign done     = busy && mem_ready_i;
  // Abort on the edge that would bring the wait count to TIMEOUT; a ready in
  // that same cycle wins.
  assign abort    = busy && !mem_ready_i && (TIMEOUT != 0) &&
                    (wait_q == WAIT_W'(TIMEOUT - 1));
  assign ret_data = (done && !we_q) ? mem_rdata_i : '0;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      IDLE: begin
        if (ls_gnt_o) begin
          state_d = BUSY_LS;
          wait_d  = '0;
          we_d    = ls_we_i;
          be_d    = ls_be_i;
          addr_d  = ls_addr_i;
          wdata_d = ls_wdata_i;
        end else if (if_gnt_o) begin
          state_d = BUSY_IF;
          wait_d  = '0;
          we_d    = 1'b0;
          be_d    = '1;
          addr_d  = if_addr_i;
          wdata_d = '0;
        end
      end
      default: begin
        if (done || abort) begin
          state_d = IDLE;
          err_d   = abort;
          if (state_q == BUSY_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = ret_data;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = ret_data;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt_o) begin
      streak_d = '0;
    end else if (ls_gnt_o && (streak_q != 4'hF)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wait_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // mem_req_o comes straight from the state register so reset drops it at once.
  assign mem_req_o   = busy;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign err_o       = err_q;

  assign stall_if_o  = if_req_i & ~if_rvalid_q;
  assign stall_mem_o = ls_req_i & ~ls_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o, if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req_i, ls_we_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o, ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              err_o, mem_req_o, mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_if_o, stall_mem_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Request sources and memory behaviour
  logic        if_pend, keep_if, ls_pend, keep_ls, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  int          mem_lat;        // ready on busy cycle index mem_lat; <0 = never
  logic        force_ready;

  // Behavioural model of the arbiter
  bit          m_busy, m_owner_ls;
  int          m_wait, m_streak;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  bit          m_if_rv, m_ls_rv, m_err;
  logic [31:0] m_if_rdata, m_ls_rdata;

  // Observed DUT events for literal checks
  byte         gnt_log[$];
  int          last_if_gnt, last_ls_gnt, last_if_rv, last_ls_rv, stall_if_cnt;
  logic [31:0] last_if_rdata, last_ls_rdata;
  logic        last_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h13;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_ls = 0; m_wait = 0; m_streak = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    m_if_rv = 0; m_ls_rv = 0; m_err = 0; m_if_rdata = 0; m_ls_rdata = 0;
    if_pend = 0; ls_pend = 0; keep_if = 0; keep_ls = 0;
  endtask

  task automatic step();
    bit          rdy, e_if_gnt, e_ls_gnt;
    logic [31:0] rd;
    if_req_i   = if_pend;
    if_addr_i  = if_addr;
    ls_req_i   = ls_pend;
    ls_we_i    = ls_we;
    ls_be_i    = ls_be;
    ls_addr_i  = ls_addr;
    ls_wdata_i = ls_wdata;
    rdy = force_ready || (m_busy && mem_lat >= 0 && m_wait == mem_lat);
    mem_ready_i = rdy;
    mem_rdata_i = rdy ? (m_busy ? mem_word(m_addr) : 32'h1234_5678) : 32'hBAD0_0000;
    e_ls_gnt = !m_busy && ls_pend && !(if_pend && m_streak == STARVE_LIMIT);
    e_if_gnt = !m_busy && if_pend && !e_ls_gnt;
    #1;
    chk("if_gnt", if_gnt_o, e_if_gnt);
    chk("ls_gnt", ls_gnt_o, e_ls_gnt);
    chk("mem_req", mem_req_o, m_busy);
    chk("if_rvalid", if_rvalid_o, m_if_rv);
    chk("ls_rvalid", ls_rvalid_o, m_ls_rv);
    chk("err", err_o, m_err);
    chk("stall_if", stall_if_o, if_pend && !m_if_rv);
    chk("stall_mem", stall_mem_o, ls_pend && !m_ls_rv);
    if (m_if_rv) chk("if_rdata", if_rdata_o, m_if_rdata);
    if (m_ls_rv) chk("ls_rdata", ls_rdata_o, m_ls_rdata);
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      if (m_owner_ls) begin
        chk("mem_be", mem_be_o, m_be);
        chk("mem_wdata", mem_wdata_o, m_wdata);
      end
    end
    if (if_gnt_o) begin last_if_gnt = cyc; gnt_log.push_back("I"); end
    if (ls_gnt_o) begin last_ls_gnt = cyc; gnt_log.push_back("L"); end
    if (if_rvalid_o) begin last_if_rv = cyc; last_if_rdata = if_rdata_o; last_err = err_o; end
    if (ls_rvalid_o) begin last_ls_rv = cyc; last_ls_rdata = ls_rdata_o; last_err = err_o; end
    if (stall_if_o) stall_if_cnt++;
    @(posedge clk_i);
    m_if_rv = 0; m_ls_rv = 0; m_err = 0;
    if (m_busy) begin
      if (rdy || (TIMEOUT != 0 && m_wait + 1 == TIMEOUT)) begin
        rd = (rdy && !m_we) ? mem_word(m_addr) : 32'h0;
        if (m_owner_ls) begin m_ls_rv = 1; m_ls_rdata = rd; end
        else begin m_if_rv = 1; m_if_rdata = rd; end
        m_err  = !rdy;
        m_busy = 0;
      end else begin
        m_wait++;
      end
    end else if (e_ls_gnt) begin
      m_busy = 1; m_owner_ls = 1; m_wait = 0;
      m_we = ls_we; m_be = ls_be; m_addr = ls_addr; m_wdata = ls_wdata;
    end else if (e_if_gnt) begin
      m_busy = 1; m_owner_ls = 0; m_wait = 0;
      m_we = 0; m_addr = if_addr;
    end
    if (!if_pend || e_if_gnt) m_streak = 0;
    else if (e_ls_gnt && m_streak < 15) m_streak++;
    if (e_if_gnt && !keep_if) if_pend = 0;
    if (e_ls_gnt && !keep_ls) ls_pend = 0;
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || if_pend || ls_pend || m_if_rv || m_ls_rv) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", (m_busy || if_pend || ls_pend || m_if_rv || m_ls_rv), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    base, rv_before;
    string exp_s;
    rst_i = 1;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; ls_we = 0;
    mem_lat = 0; force_ready = 0;
    last_if_gnt = -1; last_ls_gnt = -1; last_if_rv = -1; last_ls_rv = -1;
    last_if_rdata = 0; last_ls_rdata = 0; last_err = 0; stall_if_cnt = 0;
    model_reset();
    if_req_i = 0; if_addr_i = 0; ls_req_i = 0; ls_we_i = 0; ls_be_i = 0;
    ls_addr_i = 0; ls_wdata_i = 0; mem_ready_i = 0; mem_rdata_i = 0;
    @(negedge clk_i); #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_if_rvalid", if_rvalid_o, 0);
    chk("rst_ls_rvalid", ls_rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_ls_rdata", ls_rdata_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    @(negedge clk_i);
    rst_i = 0;

    // Single IF read, ready 3 cycles after mem_req, requester holds through rvalid
    if_pend = 1; keep_if = 1; if_addr = 32'h40; mem_lat = 3;
    base = cyc; stall_if_cnt = 0;
    for (int i = 0; i < 5; i++) step();
    if_pend = 0; keep_if = 0;
    drain(10);
    chk("s1_gnt_cyc", last_if_gnt - base, 0);
    chk("s1_rv_cyc", last_if_rv - base, 5);
    chk("s1_rdata", last_if_rdata, 32'h13);
    chk("s1_stall_cycles", stall_if_cnt, 5);

    // Simultaneous IF and LS load, zero-wait memory
    if_pend = 1; if_addr = 32'h44;
    ls_pend = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h1000; ls_wdata = 0;
    mem_lat = 0; base = cyc;
    drain(20);
    chk("s2_ls_gnt_cyc", last_ls_gnt - base, 0);
    chk("s2_ls_rv_cyc", last_ls_rv - base, 2);
    chk("s2_if_gnt_cyc", last_if_gnt - base, 2);
    chk("s2_if_rv_cyc", last_if_rv - base, 4);
    chk("s2_ls_rdata", last_ls_rdata, 32'h1000_EFFF);

    // Store with partial byte enables
    ls_pend = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF;
    mem_lat = 2; base = cyc;
    step();
    chk("s3_mem_we", mem_we_o, 1);
    chk("s3_mem_be", mem_be_o, 4'b0011);
    chk("s3_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    chk("s3_mem_addr", mem_addr_o, 32'h2004);
    drain(20);
    chk("s3_rv_cyc", last_ls_rv - base, 4);
    chk("s3_rdata", last_ls_rdata, 0);

    // Starvation: both ports request continuously
    gnt_log.delete();
    if_pend = 1; keep_if = 1; if_addr = 32'h100;
    ls_pend = 1; keep_ls = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h3000;
    mem_lat = 0;
    for (int i = 0; i < 20; i++) step();
    keep_if = 0; keep_ls = 0;
    drain(20);
    exp_s = "LLLLILLLLI";
    chk("s4_grant_count", gnt_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++) chk($sformatf("s4_order_%0d", i), gnt_log[i], exp_s[i]);

    // Memory ready while idle must be ignored
    force_ready = 1;
    step(); step();
    force_ready = 0;

    // Ready arriving on the last allowed busy cycle is a success
    ls_pend = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h3004; mem_lat = TIMEOUT - 1;
    base = cyc;
    drain(40);
    chk("s5a_rv_cyc", last_ls_rv - base, 16);
    chk("s5a_err", last_err, 0);
    chk("s5a_rdata", last_ls_rdata, 32'h3004_CFFB);

    // Timeout: memory never answers
    ls_pend = 1; ls_we = 0; ls_addr = 32'h3000; mem_lat = -1;
    base = cyc;
    drain(40);
    chk("s5_rv_cyc", last_ls_rv - base, 16);
    chk("s5_err", last_err, 1);
    chk("s5_rdata", last_ls_rdata, 0);
    if_pend = 1; if_addr = 32'h48; mem_lat = 1; base = cyc;
    drain(20);
    chk("s5_next_gnt", last_if_gnt - base, 0);
    chk("s5_next_rv", last_if_rv - base, 3);
    chk("s5_next_err", last_err, 0);

    // Reset in the middle of an IF read
    if_pend = 1; if_addr = 32'h80; mem_lat = 5;
    step(); step();
    rv_before = last_if_rv;
    rst_i = 1;
    #1;
    chk("s6_mem_req_async", mem_req_o, 0);
    chk("s6_if_rvalid", if_rvalid_o, 0);
    model_reset();
    if_req_i = 0; ls_req_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    for (int i = 0; i < 6; i++) step();
    chk("s6_no_rvalid", last_if_rv, rv_before);
    if_pend = 1; if_addr = 32'h84; mem_lat = 0; base = cyc;
    drain(20);
    chk("s6_gnt_cyc", last_if_gnt - base, 0);
    chk("s6_rv_cyc", last_if_rv - base, 2);
    chk("s6_rdata", last_if_rdata, 32'h0084_FF7B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
